// File: rtl/param_fifo.sv
// Synchronous single-clock FIFO with registered status strobes and occupancy flags.
// Define PARAM_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module param_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       rd_valid,
  output logic                       wr_ack,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       full,
  output logic                       empty,
  output logic                       almostfull,
  output logic                       almostempty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_LEVEL = CW'(AE_MARGIN);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_accept;
  logic                  rd_accept;

  // A read is judged on the current count only, so a same-cycle write cannot
  // rescue a read of an empty FIFO; a full FIFO accepts a write only alongside a read.
  always_comb begin
    rd_accept = rd_en && (count != '0);
    wr_accept = wr_en && ((count != DEPTH_C) || rd_accept);
  end

  always_comb begin
    full        = (count == DEPTH_C);
    empty       = (count == '0);
    almostfull  = (count >= AF_LEVEL) && !full;
    almostempty = (count <= AE_LEVEL) && !empty;
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      wr_ack    <= wr_accept;
      overflow  <= wr_en && !wr_accept;
      underflow <= rd_en && !rd_accept;
    end
  end

`ifdef PARAM_FIFO_FWFT_EN
  always_comb begin
    data_out = mem[rd_ptr];
    rd_valid = !empty;
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        data_out <= mem[rd_ptr];
      end
    end
  end
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo (DATA_WIDTH=16, DEPTH=8, margins 1), both read modes.
module tb_param_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] data_in = '0;
  logic        rd_en = 1'b0;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        wr_ack;
  logic        overflow;
  logic        underflow;
  logic        full;
  logic        empty;
  logic        almostfull;
  logic        almostempty;
  logic [3:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  param_fifo #(
    .DATA_WIDTH(16),
    .DEPTH(8),
    .AF_MARGIN(1),
    .AE_MARGIN(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .data_in(data_in),
    .rd_en(rd_en),
    .data_out(data_out),
    .rd_valid(rd_valid),
    .wr_ack(wr_ack),
    .overflow(overflow),
    .underflow(underflow),
    .full(full),
    .empty(empty),
    .almostfull(almostfull),
    .almostempty(almostempty),
    .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [15:0] d, input logic r);
    wr_en = w; data_in = d; rd_en = r;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  // Read the head (optionally with a concurrent write) and check the returned word.
  task automatic pop_check(input string tag, input logic w, input logic [15:0] d,
                           input logic [15:0] exp);
`ifdef PARAM_FIFO_FWFT_EN
    wr_en = w; data_in = d; rd_en = 1'b1;
    #1;
    chk({tag, "_valid"}, rd_valid, 1'b1);
    chkw({tag, "_data"}, data_out, exp);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
`else
    drive(w, d, 1'b1);
    chk({tag, "_valid"}, rd_valid, 1'b1);
    chkw({tag, "_data"}, data_out, exp);
`endif
  endtask

  task automatic check_idle(input string tag);
    chkw({tag, "_count"}, 16'(count), 16'd0);
    chk({tag, "_empty"}, empty, 1'b1);
    chk({tag, "_full"}, full, 1'b0);
    chk({tag, "_af"}, almostfull, 1'b0);
    chk({tag, "_ae"}, almostempty, 1'b0);
    chk({tag, "_wr_ack"}, wr_ack, 1'b0);
    chk({tag, "_ovf"}, overflow, 1'b0);
    chk({tag, "_unf"}, underflow, 1'b0);
    chk({tag, "_rd_valid"}, rd_valid, 1'b0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b0);
    rst = 1'b0;
    check_idle("reset");
`ifndef PARAM_FIFO_FWFT_EN
    chkw("reset_data_out", data_out, 16'h0000);
`endif

    // Fill with 0x0001..0x0008
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), 1'b0);
      chk($sformatf("fill%0d_wr_ack", i), wr_ack, 1'b1);
      chkw($sformatf("fill%0d_count", i), 16'(count), 16'(i));
      chk($sformatf("fill%0d_empty", i), empty, 1'b0);
      chk($sformatf("fill%0d_af", i), almostfull, i == 7);
      chk($sformatf("fill%0d_full", i), full, i == 8);
      chk($sformatf("fill%0d_ae", i), almostempty, i == 1);
    end

    // Write while full is rejected
    drive(1'b1, 16'hDEAD, 1'b0);
    chk("ovf_overflow", overflow, 1'b1);
    chk("ovf_wr_ack", wr_ack, 1'b0);
    chkw("ovf_count", 16'(count), 16'd8);
    chk("ovf_full", full, 1'b1);

    // Full with simultaneous read and write
    pop_check("fullrw", 1'b1, 16'h0009, 16'h0001);
    chkw("fullrw_count", 16'(count), 16'd8);
    chk("fullrw_overflow", overflow, 1'b0);
    chk("fullrw_wr_ack", wr_ack, 1'b1);
    chk("fullrw_full", full, 1'b1);

    // Drain: 0x0002..0x0009, never 0xDEAD
    for (int i = 2; i <= 9; i++) begin
      pop_check($sformatf("drain%0d", i), 1'b0, 16'h0, 16'(i));
    end
    chkw("drain_count", 16'(count), 16'd0);
    chk("drain_empty", empty, 1'b1);

    // Empty with simultaneous read and write
    drive(1'b1, 16'h00AA, 1'b1);
    chk("emptyrw_underflow", underflow, 1'b1);
    chk("emptyrw_wr_ack", wr_ack, 1'b1);
    chkw("emptyrw_count", 16'(count), 16'd1);
    chk("emptyrw_ae", almostempty, 1'b1);
`ifndef PARAM_FIFO_FWFT_EN
    chk("emptyrw_rd_valid", rd_valid, 1'b0);
    chkw("emptyrw_data_hold", data_out, 16'h0009);
`endif
    pop_check("emptyrw_read", 1'b0, 16'h0, 16'h00AA);
    chk("emptyrw_underflow_clr", underflow, 1'b0);
    chk("emptyrw_empty", empty, 1'b1);

    // Interleaved 12 writes / 12 reads, pointers wrap
    drive(1'b1, 16'h0101, 1'b0);
    chk("wrap_ae", almostempty, 1'b1);
    for (int k = 2; k <= 12; k++) begin
      pop_check($sformatf("wrap%0d", k), 1'b1, 16'(16'h0100 + k), 16'(16'h0100 + k - 1));
      chkw($sformatf("wrap%0d_count", k), 16'(count), 16'd1);
    end
    pop_check("wrap_last", 1'b0, 16'h0, 16'h010C);
    chk("wrap_empty", empty, 1'b1);
    chk("wrap_ae_end", almostempty, 1'b0);

    // Reset mid-operation at count 5, with requests asserted
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'(16'h0200 + i), 1'b0);
    end
    chkw("prerst_count", 16'(count), 16'd5);
    rst = 1'b1;
    drive(1'b1, 16'h0BAD, 1'b1);
    rst = 1'b0;
    check_idle("midrst");
    drive(1'b0, 16'h0, 1'b1);
    chk("postrst_underflow", underflow, 1'b1);
    chkw("postrst_count", 16'(count), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
